pulse_acq_ctrl: RTL and testbench
=================================

Name: pulse_acq_ctrl

Overview:
Sequencer for the 512x32 pulse-capture RAM in the AD data-processing path. It arms a capture on command and packs each DATA1/DATA0 sample pair into one RAM word. When the programmed pulse count is reached, it streams the captured words out through a valid/ready port toward the upstream packet builder. It owns the RAM write port and read address; the RAM itself is external.

Parameters:
DEPTH, 512, RAM words; maximum capture length
AW, 9, RAM address width, log2(DEPTH)
TIMEOUT, 20000, CLOCK_10M cycles allowed between samples before capture aborts (2 ms)

Ports:
CLOCK_10M  in  1  system clock, 10 MHz
RESET_N  in  1  asynchronous active-low reset
START  in  1  one-cycle pulse; arms a new acquisition
ABORT  in  1  level; forces return to IDLE
PULSE_NUM  in  AW+1  samples to capture; sampled on START
DATA0  in  16  sample low half
DATA1  in  16  sample high half
VALID  in  1  sample strobe, synchronous; a sample is taken on each 1->0 transition
WR_EN  out  1  RAM write enable
WR_ADDR  out  AW  RAM write address
WR_DATA  out  32  {DATA1, DATA0}
RD_ADDR  out  AW  RAM read address; RAM has 1-cycle registered read latency
RAM_Q  in  32  RAM read data
OUT_DATA  out  32  stream data
OUT_VALID  out  1  stream valid
OUT_READY  in  1  stream ready
OUT_LAST  out  1  marks the final word
BUSY  out  1  high in every state except IDLE
DONE  out  1  one-cycle pulse after the last word transfers
TIMEOUT_ERR  out  1  sticky; cleared by the next START

Behaviour:
- Reset: all outputs 0; FSM in IDLE; counters 0; VALID edge register 0.
- Length: N = min(PULSE_NUM, DEPTH), latched on START.
- Edge detect: VALID_d is VALID registered. A sample event is VALID_d=1 and VALID=0. DATA0/DATA1 are taken in the same cycle as the event.
- State IDLE: on START, latch N and clear wcnt, rcnt and TIMEOUT_ERR. Go to CAPTURE, or to DONE_S if N=0. START is ignored in every other state.
- State CAPTURE: on each event, drive WR_EN=1, WR_ADDR=wcnt and WR_DATA={DATA1,DATA0} registered, so the write appears 1 cycle after the event. Then increment wcnt.
  - When wcnt reaches N after the increment, go to RD_ISSUE.
  - Events beyond N are dropped.
  - Idle counter resets on each event. When it reaches TIMEOUT, set TIMEOUT_ERR, go to IDLE, and do not stream.
- State RD_ISSUE: drive RD_ADDR=rcnt; go to RD_WAIT.
- State RD_WAIT: wait one cycle for RAM latency. Load OUT_DATA from RAM_Q, assert OUT_VALID, set OUT_LAST=(rcnt==N-1), go to OUT.
- State OUT: hold OUT_DATA, OUT_VALID and OUT_LAST stable until OUT_READY=1.
  - On the transfer, increment rcnt and drop OUT_VALID.
  - If the word was the last one, go to DONE_S; otherwise go to RD_ISSUE.
  - Throughput is at most 1 word per 3 cycles, which is acceptable at pulse rates.
- State DONE_S: pulse DONE for 1 cycle, then go to IDLE.
- ABORT: has priority in every state. Go to IDLE next cycle; clear OUT_VALID and WR_EN; do not pulse DONE. A write already registered in that cycle is allowed to complete.
- Event and state exit in the same cycle: the write for the N-th event is issued even though the FSM has left CAPTURE.
- Widths: wcnt and rcnt are AW+1 bits so they can hold N=DEPTH. Addresses use the low AW bits. No wrap-around within one acquisition.
- Reset mid-operation: immediate return to the reset state. RAM contents are undefined to consumers.

Decomposition:
- Shared package pulse_acq_pkg: FSM state enum (IDLE, CAPTURE, RD_ISSUE, RD_WAIT, OUT, DONE_S), DEPTH/AW defaults, TIMEOUT default.
- One sub-module, pulse_edge_det: VALID falling-edge detector plus data register, so the write timing can be verified in isolation.
- Everything else stays in one FSM module.

Test Plan:
- START with PULSE_NUM=4; 4 VALID pulses with DATA1=16'hA000+i and DATA0=16'h0000+i, OUT_READY=1 -> 4 writes to addresses 0..3 with data 32'hA0000000..32'hA0030003. Stream outputs the same 4 words, OUT_LAST on word 3, DONE pulses once, then BUSY=0.
- PULSE_NUM=0 -> BUSY high for 2 cycles, DONE pulses, no WR_EN and no OUT_VALID.
- PULSE_NUM=600 with 520 pulses -> exactly 512 writes (last address 511), pulses 513..520 dropped, 512 words streamed.
- PULSE_NUM=3, one pulse, then silence for TIMEOUT+5 cycles -> TIMEOUT_ERR=1, IDLE, no stream, no DONE. The next START clears TIMEOUT_ERR.
- Stream with OUT_READY low for 10 cycles on word 1 -> OUT_DATA and OUT_VALID held stable, no word lost or duplicated. ABORT during OUT -> OUT_VALID drops next cycle, no DONE.
- RESET_N asserted mid-CAPTURE -> all outputs 0 immediately. A following START with PULSE_NUM=2 writes from address 0.

Source files
------------

// File: rtl/pulse_acq_pkg.sv
// Shared types and defaults for the pulse-capture RAM sequencer.
package pulse_acq_pkg;

    localparam int unsigned DEPTH_DEF   = 512;
    localparam int unsigned AW_DEF      = 9;
    localparam int unsigned TIMEOUT_DEF = 20000;

    typedef enum logic [2:0] {
        IDLE,
        CAPTURE,
        RD_ISSUE,
        RD_WAIT,
        OUT,
        DONE_S
    } acq_state_e;

endpackage

// File: rtl/pulse_edge_det.sv
// VALID falling-edge detector; captures {DATA1, DATA0} on each accepted event.
module pulse_edge_det (
    input  logic        CLOCK_10M,
    input  logic        RESET_N,
    input  logic        valid,
    input  logic        cap_en,
    input  logic [15:0] data0,
    input  logic [15:0] data1,
    output logic        sample_ev,
    output logic [31:0] sample_data
);

    logic valid_d;

    assign sample_ev = valid_d & ~valid;

    // sample_data is frozen outside capture so it can feed the read bypass
    always_ff @(posedge CLOCK_10M or negedge RESET_N) begin
        if (!RESET_N) begin
            valid_d     <= 1'b0;
            sample_data <= '0;
        end else begin
            valid_d <= valid;
            if (sample_ev && cap_en) begin
                sample_data <= {data1, data0};
            end
        end
    end

endmodule

// File: rtl/pulse_acq_ctrl.sv
// Capture sequencer: packs sample pairs into the external RAM, then streams them out.
module pulse_acq_ctrl
    import pulse_acq_pkg::*;
#(
    parameter int unsigned DEPTH   = DEPTH_DEF,
    parameter int unsigned AW      = AW_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic          CLOCK_10M,
    input  logic          RESET_N,
    input  logic          START,
    input  logic          ABORT,
    input  logic [AW:0]   PULSE_NUM,
    input  logic [15:0]   DATA0,
    input  logic [15:0]   DATA1,
    input  logic          VALID,
    output logic          WR_EN,
    output logic [AW-1:0] WR_ADDR,
    output logic [31:0]   WR_DATA,
    output logic [AW-1:0] RD_ADDR,
    input  logic [31:0]   RAM_Q,
    output logic [31:0]   OUT_DATA,
    output logic          OUT_VALID,
    input  logic          OUT_READY,
    output logic          OUT_LAST,
    output logic          BUSY,
    output logic          DONE,
    output logic          TIMEOUT_ERR
);

    localparam int unsigned TW           = $clog2(TIMEOUT + 1);
    localparam logic [AW:0] DEPTH_N      = DEPTH[AW:0];
    localparam logic [AW:0] CNT_ONE      = {{AW{1'b0}}, 1'b1};
    localparam logic [TW-1:0] IDLE_ONE   = {{(TW-1){1'b0}}, 1'b1};
    localparam logic [TW-1:0] IDLE_LAST  = TW'(TIMEOUT - 1);

    acq_state_e    state_q;
    logic [AW:0]   n_q;
    logic [AW:0]   wcnt_q;
    logic [AW:0]   rcnt_q;
    logic [TW-1:0] idle_q;
    logic          wr_en_q;
    logic [AW-1:0] wr_addr_q;
    logic [31:0]   out_data_q;
    logic          out_valid_q;
    logic          out_last_q;
    logic          done_q;
    logic          terr_q;
    logic          byp_q;
    logic          sample_ev;
    logic [31:0]   sample_data;
    logic [AW:0]   wcnt_inc;

    assign wcnt_inc = wcnt_q + CNT_ONE;

    pulse_edge_det u_edge_det (
        .CLOCK_10M   (CLOCK_10M),
        .RESET_N     (RESET_N),
        .valid       (VALID),
        .cap_en      (state_q == CAPTURE),
        .data0       (DATA0),
        .data1       (DATA1),
        .sample_ev   (sample_ev),
        .sample_data (sample_data)
    );

    always_ff @(posedge CLOCK_10M or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= IDLE;
            n_q         <= '0;
            wcnt_q      <= '0;
            rcnt_q      <= '0;
            idle_q      <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
            terr_q      <= 1'b0;
            byp_q       <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
            if (ABORT) begin
                state_q     <= IDLE;
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (START) begin
                            n_q     <= (PULSE_NUM > DEPTH_N) ? DEPTH_N : PULSE_NUM;
                            wcnt_q  <= '0;
                            rcnt_q  <= '0;
                            idle_q  <= '0;
                            terr_q  <= 1'b0;
                            state_q <= (PULSE_NUM == '0) ? DONE_S : CAPTURE;
                        end
                    end
                    CAPTURE: begin
                        if (sample_ev) begin
                            wr_en_q   <= 1'b1;
                            wr_addr_q <= wcnt_q[AW-1:0];
                            wcnt_q    <= wcnt_inc;
                            idle_q    <= '0;
                            if (wcnt_inc == n_q) begin
                                state_q <= RD_ISSUE;
                            end
                        end else if (idle_q == IDLE_LAST) begin
                            terr_q  <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            idle_q <= idle_q + IDLE_ONE;
                        end
                    end
                    RD_ISSUE: begin
                        // Final write can land on the address being read; forward it.
                        byp_q   <= wr_en_q && (wr_addr_q == rcnt_q[AW-1:0]);
                        state_q <= RD_WAIT;
                    end
                    RD_WAIT: begin
                        out_data_q  <= byp_q ? sample_data : RAM_Q;
                        out_valid_q <= 1'b1;
                        out_last_q  <= (rcnt_q == n_q - CNT_ONE);
                        state_q     <= OUT;
                    end
                    OUT: begin
                        if (OUT_READY) begin
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            rcnt_q      <= rcnt_q + CNT_ONE;
                            state_q     <= out_last_q ? DONE_S : RD_ISSUE;
                        end
                    end
                    DONE_S: begin
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign WR_EN       = wr_en_q;
    assign WR_ADDR     = wr_addr_q;
    assign WR_DATA     = sample_data;
    assign RD_ADDR     = rcnt_q[AW-1:0];
    assign OUT_DATA    = out_data_q;
    assign OUT_VALID   = out_valid_q;
    assign OUT_LAST    = out_last_q;
    // Held through the DONE pulse so consumers never see idle before completion.
    assign BUSY        = (state_q != IDLE) | done_q;
    assign DONE        = done_q;
    assign TIMEOUT_ERR = terr_q;

endmodule

// File: tb/tb_pulse_acq_ctrl.sv
// Self-checking bench for pulse_acq_ctrl with a behavioural RAM and stream scoreboard.
module tb_pulse_acq_ctrl;

    localparam int DEPTH = 512;
    localparam int AW    = 9;
    localparam int TO    = 20000;

    logic          CLOCK_10M = 1'b0;
    logic          RESET_N;
    logic          START;
    logic          ABORT;
    logic [AW:0]   PULSE_NUM;
    logic [15:0]   DATA0;
    logic [15:0]   DATA1;
    logic          VALID;
    logic          WR_EN;
    logic [AW-1:0] WR_ADDR;
    logic [31:0]   WR_DATA;
    logic [AW-1:0] RD_ADDR;
    logic [31:0]   RAM_Q;
    logic [31:0]   OUT_DATA;
    logic          OUT_VALID;
    logic          OUT_READY;
    logic          OUT_LAST;
    logic          BUSY;
    logic          DONE;
    logic          TIMEOUT_ERR;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] mon_waddr [$];
    logic [31:0]   mon_wdata [$];
    logic [31:0]   mon_odata [$];
    logic          mon_olast [$];
    int            mon_done;
    int            mon_valid;
    logic [31:0]   exp_q [$];

    pulse_acq_ctrl dut (
        .CLOCK_10M   (CLOCK_10M),
        .RESET_N     (RESET_N),
        .START       (START),
        .ABORT       (ABORT),
        .PULSE_NUM   (PULSE_NUM),
        .DATA0       (DATA0),
        .DATA1       (DATA1),
        .VALID       (VALID),
        .WR_EN       (WR_EN),
        .WR_ADDR     (WR_ADDR),
        .WR_DATA     (WR_DATA),
        .RD_ADDR     (RD_ADDR),
        .RAM_Q       (RAM_Q),
        .OUT_DATA    (OUT_DATA),
        .OUT_VALID   (OUT_VALID),
        .OUT_READY   (OUT_READY),
        .OUT_LAST    (OUT_LAST),
        .BUSY        (BUSY),
        .DONE        (DONE),
        .TIMEOUT_ERR (TIMEOUT_ERR)
    );

    always #5 CLOCK_10M = ~CLOCK_10M;

    // External 512x32 RAM, registered read
    always @(posedge CLOCK_10M) begin
        if (WR_EN) mem[WR_ADDR] <= WR_DATA;
        RAM_Q <= mem[RD_ADDR];
    end

    always @(negedge CLOCK_10M) begin
        if (WR_EN) begin
            mon_waddr.push_back(WR_ADDR);
            mon_wdata.push_back(WR_DATA);
        end
        if (OUT_VALID && OUT_READY) begin
            mon_odata.push_back(OUT_DATA);
            mon_olast.push_back(OUT_LAST);
        end
        if (DONE) mon_done++;
        if (OUT_VALID) mon_valid++;
    end

    task automatic cycle(input int n);
        repeat (n) begin
            @(posedge CLOCK_10M);
            #1;
        end
    endtask

    task automatic clear_mon();
        mon_waddr.delete();
        mon_wdata.delete();
        mon_odata.delete();
        mon_olast.delete();
        exp_q.delete();
        mon_done  = 0;
        mon_valid = 0;
    endtask

    task automatic start_acq(input int pn);
        PULSE_NUM = pn[AW:0];
        START = 1'b1;
        cycle(1);
        START = 1'b0;
        PULSE_NUM = 10'($urandom);
    endtask

    // Sample is the word present while VALID is low right after a high phase.
    task automatic send_pulse(input logic [31:0] w, input int gap);
        VALID = 1'b1;
        {DATA1, DATA0} = $urandom;
        cycle($urandom_range(1, 2));
        VALID = 1'b0;
        {DATA1, DATA0} = w;
        cycle(1);
        {DATA1, DATA0} = $urandom;
        if (gap > 1) cycle(gap - 1);
    endtask

    task automatic wait_idle(input int budget, input bit rnd_ready);
        int k = 0;
        while (BUSY && k < budget) begin
            if (rnd_ready) OUT_READY = 1'($urandom);
            cycle(1);
            k++;
        end
        OUT_READY = 1'b1;
        n_cmp++;
        if (BUSY !== 1'b0) begin
            n_err++;
            $display("FAIL wait_idle: BUSY=%b after %0d cycles, required 0", BUSY, budget);
        end
    endtask

    task automatic wait_valid(input int budget);
        int k = 0;
        while (!OUT_VALID && k < budget) begin
            cycle(1);
            k++;
        end
        n_cmp++;
        if (OUT_VALID !== 1'b1) begin
            n_err++;
            $display("FAIL wait_valid: OUT_VALID=%b after %0d cycles, required 1", OUT_VALID,
                     budget);
        end
    endtask

    task automatic test_reset();
        logic [87:0] snap;
        snap = {WR_EN, WR_ADDR, WR_DATA, RD_ADDR, OUT_DATA, OUT_VALID, OUT_LAST, BUSY, DONE,
                TIMEOUT_ERR};
        n_cmp++;
        if (snap !== '0) begin
            n_err++;
            $display("FAIL reset_in: outputs=%h, required 0", snap);
        end
        RESET_N = 1'b1;
        cycle(3);
        snap = {WR_EN, WR_ADDR, WR_DATA, RD_ADDR, OUT_DATA, OUT_VALID, OUT_LAST, BUSY, DONE,
                TIMEOUT_ERR};
        n_cmp++;
        if (snap !== '0) begin
            n_err++;
            $display("FAIL reset_out: outputs=%h, required 0", snap);
        end
    endtask

    task automatic test_basic();
        logic [31:0] w;
        clear_mon();
        OUT_READY = 1'b1;
        start_acq(4);
        for (int i = 0; i < 4; i++) begin
            w = {16'hA000 + 16'(i), 16'(i)};
            exp_q.push_back(w);
            send_pulse(w, 2);
        end
        wait_idle(100, 1'b0);
        n_cmp++;
        if (mon_waddr.size() != 4 || mon_odata.size() != 4) begin
            n_err++;
            $display("FAIL basic_count: writes=%0d words=%0d, required 4/4", mon_waddr.size(),
                     mon_odata.size());
        end
        for (int i = 0; i < 4 && i < mon_waddr.size() && i < mon_odata.size(); i++) begin
            n_cmp++;
            if (mon_waddr[i] !== AW'(i) || mon_wdata[i] !== exp_q[i] || mon_odata[i] !== exp_q[i]
                || mon_olast[i] !== (i == 3)) begin
                n_err++;
                $display("FAIL basic_word%0d: addr=%0d wr=%h out=%h last=%b, required %0d %h %h %b",
                         i, mon_waddr[i], mon_wdata[i], mon_odata[i], mon_olast[i], i, exp_q[i],
                         exp_q[i], (i == 3));
            end
        end
        n_cmp++;
        if (mon_done != 1 || BUSY !== 1'b0) begin
            n_err++;
            $display("FAIL basic_done: done=%0d busy=%b, required 1/0", mon_done, BUSY);
        end
    endtask

    task automatic test_zero();
        int busy_cycles = 0;
        clear_mon();
        start_acq(0);
        for (int i = 0; i < 6; i++) begin
            if (BUSY) busy_cycles++;
            cycle(1);
        end
        n_cmp++;
        if (busy_cycles != 2 || mon_done != 1 || mon_waddr.size() != 0 || mon_valid != 0) begin
            n_err++;
            $display("FAIL zero_len: busy=%0d done=%0d writes=%0d valid=%0d, required 2/1/0/0",
                     busy_cycles, mon_done, mon_waddr.size(), mon_valid);
        end
    endtask

    task automatic test_full();
        logic [31:0] w;
        int bad = 0;
        clear_mon();
        OUT_READY = 1'b1;
        start_acq(600);
        for (int i = 0; i < 520; i++) begin
            w = $urandom;
            if (i < DEPTH) exp_q.push_back(w);
            send_pulse(w, 1);
        end
        wait_idle(3000, 1'b0);
        n_cmp++;
        if (mon_waddr.size() != DEPTH || mon_odata.size() != DEPTH) begin
            n_err++;
            $display("FAIL full_count: writes=%0d words=%0d, required 512/512", mon_waddr.size(),
                     mon_odata.size());
        end else begin
            n_cmp++;
            if (mon_waddr[DEPTH-1] !== AW'(DEPTH - 1)) begin
                n_err++;
                $display("FAIL full_last_addr: %0d, required 511", mon_waddr[DEPTH-1]);
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (mon_waddr[i] !== AW'(i) || mon_wdata[i] !== exp_q[i] ||
                    mon_odata[i] !== exp_q[i] || mon_olast[i] !== (i == DEPTH - 1)) bad++;
            end
            n_cmp++;
            if (bad != 0) begin
                n_err++;
                $display("FAIL full_words: %0d bad words, required 0", bad);
            end
        end
        n_cmp++;
        if (mon_done != 1) begin
            n_err++;
            $display("FAIL full_done: done=%0d, required 1", mon_done);
        end
    endtask

    task automatic test_timeout();
        clear_mon();
        OUT_READY = 1'b1;
        start_acq(3);
        send_pulse(32'h1234_5678, 2);
        cycle(TO + 5);
        n_cmp++;
        if (TIMEOUT_ERR !== 1'b1 || BUSY !== 1'b0) begin
            n_err++;
            $display("FAIL timeout_flag: err=%b busy=%b, required 1/0", TIMEOUT_ERR, BUSY);
        end
        n_cmp++;
        if (mon_waddr.size() != 1 || mon_valid != 0 || mon_done != 0) begin
            n_err++;
            $display("FAIL timeout_quiet: writes=%0d valid=%0d done=%0d, required 1/0/0",
                     mon_waddr.size(), mon_valid, mon_done);
        end
        start_acq(2);
        n_cmp++;
        if (TIMEOUT_ERR !== 1'b0) begin
            n_err++;
            $display("FAIL timeout_clear: err=%b, required 0", TIMEOUT_ERR);
        end
        ABORT = 1'b1;
        cycle(1);
        ABORT = 1'b0;
        n_cmp++;
        if (BUSY !== 1'b0) begin
            n_err++;
            $display("FAIL abort_capture: busy=%b, required 0", BUSY);
        end
    endtask

    task automatic test_stall_abort();
        logic [31:0] w;
        clear_mon();
        OUT_READY = 1'b0;
        start_acq(3);
        for (int i = 0; i < 3; i++) begin
            w = $urandom;
            exp_q.push_back(w);
            send_pulse(w, 2);
        end
        wait_valid(20);
        OUT_READY = 1'b1;
        cycle(1);
        OUT_READY = 1'b0;
        wait_valid(20);
        for (int i = 0; i < 10; i++) begin
            n_cmp++;
            if (OUT_VALID !== 1'b1 || OUT_DATA !== exp_q[1]) begin
                n_err++;
                $display("FAIL stall_hold%0d: valid=%b data=%h, required 1 %h", i, OUT_VALID,
                         OUT_DATA, exp_q[1]);
            end
            cycle(1);
        end
        wait_idle(100, 1'b1);
        n_cmp++;
        if (mon_odata.size() != 3) begin
            n_err++;
            $display("FAIL stall_count: words=%0d, required 3", mon_odata.size());
        end
        for (int i = 0; i < 3 && i < mon_odata.size(); i++) begin
            n_cmp++;
            if (mon_odata[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL stall_word%0d: %h, required %h", i, mon_odata[i], exp_q[i]);
            end
        end
        clear_mon();
        OUT_READY = 1'b0;
        start_acq(2);
        send_pulse($urandom, 2);
        send_pulse($urandom, 2);
        wait_valid(20);
        ABORT = 1'b1;
        cycle(1);
        ABORT = 1'b0;
        n_cmp++;
        if (OUT_VALID !== 1'b0 || BUSY !== 1'b0) begin
            n_err++;
            $display("FAIL abort_out: valid=%b busy=%b, required 0/0", OUT_VALID, BUSY);
        end
        OUT_READY = 1'b1;
        cycle(4);
        n_cmp++;
        if (mon_done != 0 || mon_odata.size() != 0) begin
            n_err++;
            $display("FAIL abort_done: done=%0d words=%0d, required 0/0", mon_done,
                     mon_odata.size());
        end
    endtask

    task automatic test_reset_mid();
        logic [87:0] snap;
        logic [31:0] w;
        clear_mon();
        OUT_READY = 1'b1;
        start_acq(5);
        send_pulse($urandom, 2);
        send_pulse($urandom, 1);
        RESET_N = 1'b0;
        #1;
        snap = {WR_EN, WR_ADDR, WR_DATA, RD_ADDR, OUT_DATA, OUT_VALID, OUT_LAST, BUSY, DONE,
                TIMEOUT_ERR};
        n_cmp++;
        if (snap !== '0) begin
            n_err++;
            $display("FAIL reset_mid: outputs=%h, required 0", snap);
        end
        cycle(2);
        RESET_N = 1'b1;
        cycle(1);
        clear_mon();
        start_acq(2);
        for (int i = 0; i < 2; i++) begin
            w = $urandom;
            exp_q.push_back(w);
            send_pulse(w, 2);
        end
        wait_idle(100, 1'b0);
        n_cmp++;
        if (mon_waddr.size() != 2 || mon_odata.size() != 2) begin
            n_err++;
            $display("FAIL reset_restart_count: writes=%0d words=%0d, required 2/2",
                     mon_waddr.size(), mon_odata.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                n_cmp++;
                if (mon_waddr[i] !== AW'(i) || mon_odata[i] !== exp_q[i]) begin
                    n_err++;
                    $display("FAIL reset_restart%0d: addr=%0d out=%h, required %0d %h", i,
                             mon_waddr[i], mon_odata[i], i, exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_random();
        int pn;
        int extra;
        logic [31:0] w;
        for (int it = 0; it < 6; it++) begin
            clear_mon();
            OUT_READY = 1'b1;
            pn = (it == 0) ? 1 : $urandom_range(1, 24);
            extra = $urandom_range(0, 3);
            start_acq(pn);
            for (int i = 0; i < pn + extra; i++) begin
                w = $urandom;
                if (i < pn) exp_q.push_back(w);
                send_pulse(w, $urandom_range(1, 3));
            end
            wait_idle(400, 1'b1);
            n_cmp++;
            if (mon_waddr.size() != pn || mon_odata.size() != pn || mon_done != 1) begin
                n_err++;
                $display("FAIL rand%0d_count: writes=%0d words=%0d done=%0d, required %0d/%0d/1",
                         it, mon_waddr.size(), mon_odata.size(), mon_done, pn, pn);
            end else begin
                for (int i = 0; i < pn; i++) begin
                    n_cmp++;
                    if (mon_waddr[i] !== AW'(i) || mon_wdata[i] !== exp_q[i] ||
                        mon_odata[i] !== exp_q[i] || mon_olast[i] !== (i == pn - 1)) begin
                        n_err++;
                        $display("FAIL rand%0d_word%0d: addr=%0d wr=%h out=%h last=%b, req %h",
                                 it, i, mon_waddr[i], mon_wdata[i], mon_odata[i], mon_olast[i],
                                 exp_q[i]);
                    end
                end
            end
        end
    endtask

    initial begin
        RESET_N   = 1'b0;
        START     = 1'b0;
        ABORT     = 1'b0;
        PULSE_NUM = '0;
        DATA0     = '0;
        DATA1     = '0;
        VALID     = 1'b0;
        OUT_READY = 1'b1;
        cycle(2);
        test_reset();
        test_basic();
        test_zero();
        test_random();
        test_full();
        test_stall_abort();
        test_timeout();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
